// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with frame-aligned double buffering.
// Define SEG7_ZERO_BLANK_EN to enable leading-zero suppression.
module seg7_scan_driver #(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned GUARD    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic        load,
    output logic        busy,
    output logic        frame_start,
    output logic [7:0]  AN,
    output logic [6:0]  A2G,
    output logic        DP
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc;
    logic [2:0]    dig;
    logic [31:0]   pend_data;
    logic [7:0]    pend_dp;
    logic [31:0]   disp_data;
    logic [7:0]    disp_dp;
    logic          slot_end;
    logic          boundary;
    logic          in_guard;
    logic [7:0]    keep;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    assign slot_end = (presc == PW'(PRESCALE - 1));
    assign boundary = slot_end && (dig == 3'd7);
    assign in_guard = (presc < PW'(GUARD));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            dig   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            dig   <= dig + 3'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // A load on the boundary itself bypasses the pending stage entirely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_data <= '0;
            pend_dp   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
            busy      <= 1'b0;
        end else if (load && boundary) begin
            disp_data <= data;
            disp_dp   <= dp_in;
            busy      <= 1'b0;
        end else if (load) begin
            pend_data <= data;
            pend_dp   <= dp_in;
            busy      <= 1'b1;
        end else if (boundary && busy) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
            busy      <= 1'b0;
        end
    end

`ifdef SEG7_ZERO_BLANK_EN
    // Scan from the top digit down; once anything visible is seen, every lower digit stays lit.
    always_comb begin
        logic lit;
        lit  = 1'b0;
        keep = '0;
        for (int i = 7; i >= 0; i--) begin
            lit     = lit | (disp_data[4*i +: 4] != 4'h0) | disp_dp[i] | (i == 0);
            keep[i] = lit;
        end
    end
`else
    assign keep = 8'hFF;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AN          <= 8'hFF;
            A2G         <= 7'h7F;
            DP          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (presc == '0) && (dig == 3'd0);
            if (in_guard) begin
                AN  <= 8'hFF;
                A2G <= 7'h7F;
                DP  <= 1'b1;
            end else begin
                AN  <= ~(8'b1 << dig);
                A2G <= keep[dig] ? hex7(disp_data[4*dig +: 4]) : 7'h7F;
                DP  <= ~disp_dp[dig];
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with PRESCALE=8, GUARD=2 (64-cycle frames).
// Expected leading-zero behaviour follows SEG7_ZERO_BLANK_EN when it is defined.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic [7:0]  dp_in;
    logic        load;
    logic        busy;
    logic        frame_start;
    logic [7:0]  AN;
    logic [6:0]  A2G;
    logic        DP;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seg7_scan_driver #(.PRESCALE(8), .GUARD(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .dp_in       (dp_in),
        .load        (load),
        .busy        (busy),
        .frame_start (frame_start),
        .AN          (AN),
        .A2G         (A2G),
        .DP          (DP)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segOf(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[n];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Outputs after a tick describe the scan state of the previous cycle.
    task automatic checkOutput(input logic [31:0] expData, input logic [7:0] expDp);
        int s, p, d;
        logic [7:0] eAn;
        logic [6:0] eSeg;
        logic       eDp;
        logic       blank;
        s = cyc - 1;
        p = s % 8;
        d = (s / 8) % 8;
        if (p < 2) begin
            eAn = 8'hFF; eSeg = 7'h7F; eDp = 1'b1;
        end else begin
            eAn  = ~(8'b1 << d);
            eSeg = segOf(expData[4*d +: 4]);
            eDp  = ~expDp[d];
            blank = 1'b0;
`ifdef SEG7_ZERO_BLANK_EN
            blank = (d != 0);
            for (int j = d; j < 8; j++)
                if (expData[4*j +: 4] != 4'h0 || expDp[j]) blank = 1'b0;
`endif
            if (blank) eSeg = 7'h7F;
        end
        chk("AN", 32'(AN), 32'(eAn));
        chk("A2G", 32'(A2G), 32'(eSeg));
        chk("DP", 32'(DP), 32'(eDp));
        chk("frame_start", 32'(frame_start), 32'((p == 0) && (d == 0)));
    endtask

    task automatic runTo(input int target, input logic [31:0] expData, input logic [7:0] expDp);
        while (cyc < target) begin
            tick();
            checkOutput(expData, expDp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [7:0] dp,
                                 input logic [31:0] expData, input logic [7:0] expDp);
        data  = d;
        dp_in = dp;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        checkOutput(expData, expDp);
    endtask

    initial begin
        reset = 1'b0;
        load  = 1'b0;
        data  = '0;
        dp_in = '0;
        #12;
        chk("rst_AN", 32'(AN), 32'h FF);
        chk("rst_A2G", 32'(A2G), 32'h7F);
        chk("rst_DP", 32'(DP), 32'h1);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        cyc   = 0;

        // Idle scan of the zero value.
        runTo(3, 32'h0, 8'h0);
        chk("first_anode", 32'(AN), 32'hFE);
        runTo(64, 32'h0, 8'h0);

        // Mid-frame load waits for the boundary.
        runTo(84, 32'h0, 8'h0);
        applyStimulus(32'h1234ABCD, 8'h01, 32'h0, 8'h0);
        chk("busy_after_load", 32'(busy), 32'h1);
        runTo(127, 32'h0, 8'h0);
        chk("busy_before_boundary", 32'(busy), 32'h1);
        runTo(128, 32'h0, 8'h0);
        chk("busy_after_boundary", 32'(busy), 32'h0);
        runTo(131, 32'h1234ABCD, 8'h01);
        chk("d0_AN", 32'(AN), 32'hFE);
        chk("d0_A2G", 32'(A2G), 32'(7'b1000010));
        chk("d0_DP", 32'(DP), 32'h0);
        runTo(187, 32'h1234ABCD, 8'h01);
        chk("d7_AN", 32'(AN), 32'h7F);
        chk("d7_A2G", 32'(A2G), 32'(7'b1001111));
        runTo(192, 32'h1234ABCD, 8'h01);

        // Two loads in one frame: last one wins.
        runTo(200, 32'h1234ABCD, 8'h01);
        applyStimulus(32'h11111111, 8'h00, 32'h1234ABCD, 8'h01);
        runTo(220, 32'h1234ABCD, 8'h01);
        applyStimulus(32'h22222222, 8'h00, 32'h1234ABCD, 8'h01);
        chk("busy_second_load", 32'(busy), 32'h1);
        runTo(256, 32'h1234ABCD, 8'h01);
        runTo(291, 32'h22222222, 8'h00);
        chk("d4_AN", 32'(AN), 32'hEF);
        chk("d4_A2G", 32'(A2G), 32'(7'b0010010));
        runTo(319, 32'h22222222, 8'h00);

        // Load on the boundary cycle goes straight to display.
        chk("busy_pre_boundary_load", 32'(busy), 32'h0);
        applyStimulus(32'hFEDCBA98, 8'h80, 32'h22222222, 8'h00);
        chk("busy_boundary_load", 32'(busy), 32'h0);
        runTo(323, 32'hFEDCBA98, 8'h80);
        chk("bnd_d0_A2G", 32'(A2G), 32'(7'b0000000));
        chk("busy_boundary_load2", 32'(busy), 32'h0);
        runTo(384, 32'hFEDCBA98, 8'h80);

        // Asynchronous reset while digit 5 is lit and a value is pending.
        runTo(390, 32'hFEDCBA98, 8'h80);
        applyStimulus(32'h55555555, 8'hFF, 32'hFEDCBA98, 8'h80);
        runTo(428, 32'hFEDCBA98, 8'h80);
        chk("d5_AN", 32'(AN), 32'hDF);
        chk("d5_A2G", 32'(A2G), 32'(7'b1000010));
        chk("busy_before_reset", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_AN", 32'(AN), 32'hFF);
        chk("async_A2G", 32'(A2G), 32'h7F);
        chk("async_DP", 32'(DP), 32'h1);
        chk("async_busy", 32'(busy), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("held_AN", 32'(AN), 32'hFF);
        reset = 1'b1;
        cyc   = 0;
        runTo(3, 32'h0, 8'h0);
        chk("restart_AN", 32'(AN), 32'hFE);
        chk("restart_A2G", 32'(A2G), 32'(7'b0000001));
        runTo(70, 32'h0, 8'h0);
        chk("pending_discarded", 32'(busy), 32'h0);

        // Small value exercises leading-zero handling and DP protection.
        applyStimulus(32'h00000042, 8'h00, 32'h0, 8'h0);
        runTo(128, 32'h0, 8'h0);
        runTo(139, 32'h00000042, 8'h00);
        chk("zb_d1_A2G", 32'(A2G), 32'(7'b1001100));
        runTo(155, 32'h00000042, 8'h00);
        chk("zb_d3_AN", 32'(AN), 32'hF7);
`ifdef SEG7_ZERO_BLANK_EN
        chk("zb_d3_A2G", 32'(A2G), 32'h7F);
`else
        chk("zb_d3_A2G", 32'(A2G), 32'(7'b0000001));
`endif
        runTo(200, 32'h00000042, 8'h00);
        applyStimulus(32'h00000042, 8'h20, 32'h00000042, 8'h00);
        runTo(256, 32'h00000042, 8'h00);
        runTo(299, 32'h00000042, 8'h20);
        chk("zb_d5_AN", 32'(AN), 32'hDF);
        chk("zb_d5_A2G", 32'(A2G), 32'(7'b0000001));
        chk("zb_d5_DP", 32'(DP), 32'h0);
        runTo(307, 32'h00000042, 8'h20);
`ifdef SEG7_ZERO_BLANK_EN
        chk("zb_d6_A2G", 32'(A2G), 32'h7F);
`else
        chk("zb_d6_A2G", 32'(A2G), 32'(7'b0000001));
`endif
        runTo(320, 32'h00000042, 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's eight-digit seven-segment display, sitting directly downstream of the processor top-level display value. It takes a 32-bit value and a decimal-point mask, double-buffers them so a frame is never torn, and scans the digits one at a time on `AN`, `A2G` and `DP`. It uses a programmable slot length and an anti-ghosting blank interval.

## Interface
- `PRESCALE`, 100000: clock cycles per digit slot, at least 4; one frame is 8 slots.
- `GUARD`, 4: cycles at the start of each slot with all anodes off; must be less than `PRESCALE`.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `data` in 32: display value; digit i shows nibble `data[4i+3:4i]`, digit 0 is rightmost.
- `dp_in` in 8: decimal-point request, bit i lights the DP of digit i.
- `load` in 1: single-cycle strobe that captures `data` and `dp_in`.
- `busy` out 1: high while a captured value waits for the frame boundary.
- `frame_start` out 1: one-cycle pulse when digit 0's slot begins.
- `AN` out 8: anode enables, active-low, at most one bit low.
- `A2G` out 7: segments a..g on bits 6..0, active-low.
- `DP` out 1: decimal point, active-low.

## Operation
- Prescaler `presc` counts 0..PRESCALE-1 and wraps. At the wrap, digit index `dig` advances 0→7→0.
- The frame boundary is the cycle where `presc==PRESCALE-1` and `dig==7`.
- Double buffering:
  - `load` writes `pend_data`/`pend_dp` and sets `busy`.
  - At the frame boundary, if `busy` is set, the pending values move to `disp_data`/`disp_dp` and `busy` clears.
  - `load` on the boundary cycle itself writes `disp_*` directly and leaves `busy` clear.
  - A second `load` while `busy` is set overwrites the pending values; last writer wins.
- Output generation:
  - When `presc<GUARD`: `AN=8'hFF`, `A2G=7'h7F`, `DP=1`.
  - Otherwise: `AN=~(1<<dig)`, `A2G=hex(disp nibble dig)`, `DP=~disp_dp[dig]`.
- Hex encoding, active-low: 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100, A→0001000, b→1100000, C→0110001, d→1000010, E→0110000, F→0111000.
- `frame_start` is registered high for the one cycle where `presc==0` and `dig==0`.

## Timing
- Reset values:
  - `presc=0`, `dig=0`, `disp_*=0`, `pend_*=0`, `busy=0`.
  - `AN=8'hFF`, `A2G=7'h7F`, `DP=1`, `frame_start=0`.
- Reset assertion forces all outputs to their reset values immediately, including mid-slot or mid-frame. Pending data is discarded.
- `AN`, `A2G`, `DP` and `frame_start` are registered: they reflect the `(presc, dig)` state of the previous cycle, a latency of 1 cycle.
- The first cycle after reset release counts as `presc=0`, `dig=0`. Digit 0 anode goes low at cycle GUARD+1.
- A new value reaches the display at most 8·PRESCALE+1 cycles after `load`.
- `busy` rises the cycle after `load` and falls the cycle after the frame boundary.

## Configuration
- `SEG7_ZERO_BLANK_EN` defined:
  - Leading-zero suppression. Digits above the most significant non-zero nibble of `disp_data` show `A2G=7'h7F`, and their anode is still driven.
  - Digit 0 is never blanked.
  - A digit whose `disp_dp` bit is set is never blanked, and no digit below it is blanked either.
- Not defined: all eight digits always display their hex nibble.

## Test plan
All scenarios use PRESCALE=8, GUARD=2.
- Reset, then run 64 cycles with `disp=0` → `AN` cycles FE,FD,...,7F with 2 guard cycles of FF per slot, `A2G=0000001` whenever an anode is active, `frame_start` high once every 64 cycles.
- `load` with `data=32'h1234ABCD`, `dp_in=8'h01` mid-frame → `busy=1` until the boundary. Next frame: digit 0 shows d (1000010) with `DP=0`, digit 7 shows 1 (1001111). No mixed frame occurs.
- Two `load`s in one frame (`32'h11111111`, then `32'h22222222`) → only 2 (0010010) appears on the next frame.
- `load` on the exact boundary cycle → `busy` stays 0 and the new value shows from digit 0 of the following slot.
- Assert `reset` while digit 5 is active and `busy=1` → `AN=FF`, `A2G=7F` asynchronously. After release, scanning restarts at digit 0 showing 0.
- With `SEG7_ZERO_BLANK_EN` and `data=32'h00000042`, `dp_in=0` → digits 2..7 show 7F, digit 1 shows 4, digit 0 shows 2. With `dp_in=8'h20`, digits 2..4 and 5 show 0.
